// File: rtl/clk_div_prog_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Optional duty-cycle control is enabled with the CLK_DIV_PROG_DUTY_EN macro.
package clk_div_prog_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_e;

    localparam int unsigned DIV_MIN = 2;

    // Ratios below DIV_MIN cannot form a low and a high phase.
    function automatic int unsigned clamp_div(input int unsigned div);
        return (div < DIV_MIN) ? DIV_MIN : div;
    endfunction

`ifdef CLK_DIV_PROG_DUTY_EN
    // The high phase must leave at least one low cycle in the period.
    function automatic int unsigned clamp_high(input int unsigned high, input int unsigned div);
        if (high < 1)
            return 1;
        if (high > div - 1)
            return div - 1;
        return high;
    endfunction
`endif

endpackage

// File: rtl/clk_div_ratio_hold.sv
// Pending/active ratio registers for clk_div_prog; a new ratio becomes active only
// when the owner signals a period boundary (or idle). Duty input under CLK_DIV_PROG_DUTY_EN.
module clk_div_ratio_hold
    import clk_div_prog_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int DIV_RST = 2
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic [DIV_W-1:0] div_i,
`ifdef CLK_DIV_PROG_DUTY_EN
    input  logic [DIV_W-1:0] high_i,
`endif
    input  logic             div_vld_i,
    input  logic             apply_ok,
    output logic             div_rdy_o,
    output logic [DIV_W-1:0] div_o,
    output logic [DIV_W-1:0] low_o
);

    // Handshake: a load transfers when div_vld_i && div_rdy_o at a rising edge;
    // div_rdy_o stays low while a value is pending and the requester must hold
    // div_vld_i (ignored meanwhile) until it returns high.
    logic             pend_vld;
    logic [DIV_W-1:0] pend_div;
    logic [DIV_W-1:0] pend_low;
    logic [DIV_W-1:0] div_c;
    logic [DIV_W-1:0] low_c;

    always_comb begin
        div_c = DIV_W'(clamp_div(32'(div_i)));
`ifdef CLK_DIV_PROG_DUTY_EN
        low_c = div_c - DIV_W'(clamp_high(32'(high_i), 32'(div_c)));
`else
        low_c = div_c >> 1;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            pend_vld <= 1'b0;
            pend_div <= '0;
            pend_low <= '0;
            div_o    <= DIV_W'(DIV_RST);
            low_o    <= DIV_W'(DIV_RST / 2);
        end else if (pend_vld && apply_ok) begin
            div_o    <= pend_div;
            low_o    <= pend_low;
            pend_vld <= 1'b0;
        end else if (div_vld_i && !pend_vld) begin
            pend_vld <= 1'b1;
            pend_div <= div_c;
            pend_low <= low_c;
        end
    end

    assign div_rdy_o = ~pend_vld;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with registered clk_o and edge strobes.
// Define CLK_DIV_PROG_DUTY_EN to add the high_i duty-cycle input.
module clk_div_prog
    import clk_div_prog_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int DIV_RST = 2
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
`ifdef CLK_DIV_PROG_DUTY_EN
    input  logic [DIV_W-1:0] high_i,
`endif
    input  logic             div_vld_i,
    output logic             div_rdy_o,
    output logic             clk_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             running_o,
    output state_e           state_o
);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_n, low_n;
    logic             wrap;
    logic             clk_d;

    assign wrap = (state_q != IDLE) && (cnt_q == div_n - DIV_W'(1));

    clk_div_ratio_hold #(
        .DIV_W   (DIV_W),
        .DIV_RST (DIV_RST)
    ) u_ratio (
        .clk_i     (clk_i),
        .rst       (rst),
        .div_i     (div_i),
`ifdef CLK_DIV_PROG_DUTY_EN
        .high_i    (high_i),
`endif
        .div_vld_i (div_vld_i),
        .apply_ok  ((state_q == IDLE) || wrap),
        .div_rdy_o (div_rdy_o),
        .div_o     (div_n),
        .low_o     (low_n)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (en_i)
                    state_d = RUN;
            end
            RUN: begin
                cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
                if (!en_i)
                    state_d = STOPPING;
            end
            STOPPING: begin
                cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
                if (en_i)
                    state_d = RUN;
                else if (wrap)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A ratio change lands only where cnt_d is 0, which is low for any ratio.
        clk_d = (cnt_d >= low_n);
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            clk_o   <= 1'b0;
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clk_o   <= clk_d;
            rise_o  <= clk_d & ~clk_o;
            fall_o  <= ~clk_d & clk_o;
        end
    end

    assign running_o = (state_q != IDLE);
    assign state_o   = state_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog against a cycle-level behavioural model.
// Build with CLK_DIV_PROG_DUTY_EN defined to cover the duty-cycle input as well.
module tb_clk_div_prog;
    import clk_div_prog_pkg::*;

    localparam int DIV_W   = 8;
    localparam int DIV_RST = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             en_i      = 1'b0;
    logic             div_vld_i = 1'b0;
    logic [DIV_W-1:0] div_i     = '0;
`ifdef CLK_DIV_PROG_DUTY_EN
    logic [DIV_W-1:0] high_i    = '0;
`endif
    logic   div_rdy_o, clk_o, rise_o, fall_o, running_o;
    state_e state_o;

    clk_div_prog #(
        .DIV_W   (DIV_W),
        .DIV_RST (DIV_RST)
    ) dut (
        .clk_i     (clk),
        .rst       (rst),
        .en_i      (en_i),
        .div_i     (div_i),
`ifdef CLK_DIV_PROG_DUTY_EN
        .high_i    (high_i),
`endif
        .div_vld_i (div_vld_i),
        .div_rdy_o (div_rdy_o),
        .clk_o     (clk_o),
        .rise_o    (rise_o),
        .fall_o    (fall_o),
        .running_o (running_o),
        .state_o   (state_o)
    );

    // ---------------- scoreboard ----------------
    int         n_chk  = 0;
    int         n_pass = 0;
    logic [4:0] exp_q[$];
    logic [4:0] obs, expv;
    logic       pat_n4 [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       pat_n5 [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       pat_n2 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    // Behavioural model: position within the period, ratio, high length, pending load.
    bit m_active, m_stopping, m_pend, m_clk;
    int m_pos, m_n, m_hi, m_pend_n, m_pend_hi;

    task automatic model_step();
        bit wrap, accept, new_clk, rise, fall;
        int req_n, req_hi;
        if (rst) begin
            m_active = 0; m_stopping = 0; m_pos = 0; m_pend = 0; m_clk = 0;
            m_n = DIV_RST; m_hi = DIV_RST - DIV_RST / 2;
            exp_q.push_back(5'b00010);
            return;
        end
        wrap   = m_active && (m_pos == m_n - 1);
        accept = div_vld_i && !m_pend;
        if (m_pend && (!m_active || wrap)) begin
            m_n = m_pend_n; m_hi = m_pend_hi; m_pend = 0;
        end
        if (accept) begin
            req_n = (int'(div_i) < 2) ? 2 : int'(div_i);
`ifdef CLK_DIV_PROG_DUTY_EN
            req_hi = int'(high_i);
            if (req_hi < 1) req_hi = 1;
            if (req_hi > req_n - 1) req_hi = req_n - 1;
`else
            req_hi = (req_n + 1) / 2;
`endif
            m_pend = 1; m_pend_n = req_n; m_pend_hi = req_hi;
        end
        if (!m_active) begin
            m_pos = 0; m_active = en_i; m_stopping = 0;
        end else begin
            m_pos = wrap ? 0 : m_pos + 1;
            if (en_i) m_stopping = 0;
            else if (m_stopping && wrap) begin m_active = 0; m_stopping = 0; end
            else m_stopping = 1;
        end
        new_clk = m_active && (m_pos >= m_n - m_hi);
        rise    = new_clk && !m_clk;
        fall    = !new_clk && m_clk;
        m_clk   = new_clk;
        exp_q.push_back({m_clk, rise, fall, !m_pend, m_active});
    endtask

    // ---------------- driver ----------------
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; en_i = 1'b0; div_vld_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
            if (obs !== expv) $display("FAIL reset got=%b want=%b", obs, expv); else n_pass++;
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
            if (obs !== expv) $display("FAIL idle t=%0t got=%b want=%b", $time, obs, expv); else n_pass++;
        end
        n_chk++;
        if (state_o !== IDLE) $display("FAIL idle_state got=%0d want=%0d", state_o, IDLE); else n_pass++;
    endtask

    task automatic test_default_ratio();
        int rises = 0;
        int falls = 0;
        en_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
            if (obs !== expv) $display("FAIL default t=%0t got=%b want=%b", $time, obs, expv); else n_pass++;
            n_chk++;
            if (clk_o !== pat_n4[i]) $display("FAIL default_pat i=%0d got=%b want=%b", i, clk_o, pat_n4[i]); else n_pass++;
        end
        for (int i = 0; i < 16; i++) begin
            cycle();
            n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
            if (obs !== expv) $display("FAIL default t=%0t got=%b want=%b", $time, obs, expv); else n_pass++;
            rises += int'(rise_o);
            falls += int'(fall_o);
        end
        n_chk++;
        if (rises != 4 || falls != 4) $display("FAIL default_strobes got=%0d/%0d want=4/4", rises, falls); else n_pass++;
    endtask

    task automatic test_odd_ratio();
        en_i = 1'b0;
        for (int i = 0; i < 20 && running_o; i++) begin
            cycle();
            n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
            if (obs !== expv) $display("FAIL odd_stop t=%0t got=%b want=%b", $time, obs, expv); else n_pass++;
        end
        n_chk++;
        if (running_o !== 1'b0) $display("FAIL odd_stop_timeout got=%b want=0", running_o); else n_pass++;
        div_i = 8'd5; div_vld_i = 1'b1;
        cycle();
        n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
        if (obs !== expv) $display("FAIL odd_load got=%b want=%b", obs, expv); else n_pass++;
        n_chk++;
        if (div_rdy_o !== 1'b0) $display("FAIL odd_rdy_low got=%b want=0", div_rdy_o); else n_pass++;
        div_vld_i = 1'b0;
        cycle();
        n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
        if (obs !== expv) $display("FAIL odd_apply got=%b want=%b", obs, expv); else n_pass++;
        en_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
            if (obs !== expv) $display("FAIL odd t=%0t got=%b want=%b", $time, obs, expv); else n_pass++;
            if (i < 5) begin
                n_chk++;
                if (clk_o !== pat_n5[i]) $display("FAIL odd_pat i=%0d got=%b want=%b", i, clk_o, pat_n5[i]); else n_pass++;
            end
        end
    endtask

    task automatic test_rate_change();
        rst = 1'b1;
        cycle();
        n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
        if (obs !== expv) $display("FAIL rate_reset got=%b want=%b", obs, expv); else n_pass++;
        rst = 1'b0; en_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
            if (obs !== expv) $display("FAIL rate_pre t=%0t got=%b want=%b", $time, obs, expv); else n_pass++;
        end
        div_i = 8'd6; div_vld_i = 1'b1;
        cycle();
        n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
        if (obs !== expv) $display("FAIL rate_accept got=%b want=%b", obs, expv); else n_pass++;
        n_chk++;
        if (div_rdy_o !== 1'b0) $display("FAIL rate_rdy_low got=%b want=0", div_rdy_o); else n_pass++;
        div_i = 8'd9;
        cycle();
        n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
        if (obs !== expv) $display("FAIL rate_ignored got=%b want=%b", obs, expv); else n_pass++;
        div_vld_i = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
            if (obs !== expv) $display("FAIL rate t=%0t got=%b want=%b", $time, obs, expv); else n_pass++;
        end
    endtask

    task automatic test_stop_clamp();
        bit saw_fall = 0;
        for (int i = 0; i < 10 && clk_o !== 1'b1; i++) begin
            cycle();
            n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
            if (obs !== expv) $display("FAIL stop_wait got=%b want=%b", obs, expv); else n_pass++;
        end
        n_chk++;
        if (clk_o !== 1'b1) $display("FAIL stop_high_timeout got=%b want=1", clk_o); else n_pass++;
        en_i = 1'b0;
        for (int i = 0; i < 40 && running_o; i++) begin
            cycle();
            n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
            if (obs !== expv) $display("FAIL stop t=%0t got=%b want=%b", $time, obs, expv); else n_pass++;
            if (fall_o === 1'b1) saw_fall = 1;
        end
        n_chk++;
        if (running_o !== 1'b0 || !saw_fall) $display("FAIL stop_final got=%b/%b want=0/1", running_o, saw_fall); else n_pass++;
        for (int k = 0; k < 2; k++) begin
            div_i = (k == 0) ? 8'd0 : 8'd1; div_vld_i = 1'b1; en_i = 1'b0;
            for (int i = 0; i < 2; i++) begin
                cycle();
                n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
                if (obs !== expv) $display("FAIL clamp_load got=%b want=%b", obs, expv); else n_pass++;
                div_vld_i = 1'b0;
            end
            en_i = 1'b1;
            for (int i = 0; i < 10; i++) begin
                cycle();
                n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
                if (obs !== expv) $display("FAIL clamp t=%0t got=%b want=%b", $time, obs, expv); else n_pass++;
                if (i < 4) begin
                    n_chk++;
                    if (clk_o !== pat_n2[i]) $display("FAIL clamp_pat div=%0d i=%0d got=%b want=%b", div_i, i, clk_o, pat_n2[i]); else n_pass++;
                end
            end
            en_i = 1'b0;
            for (int i = 0; i < 8 && running_o; i++) begin
                cycle();
                n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
                if (obs !== expv) $display("FAIL clamp_stop got=%b want=%b", obs, expv); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        en_i = 1'b1;
        for (int i = 0; i < 10 && clk_o !== 1'b1; i++) begin
            cycle();
            n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
            if (obs !== expv) $display("FAIL rstmid_wait got=%b want=%b", obs, expv); else n_pass++;
        end
        rst = 1'b1;
        cycle();
        n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
        if (obs !== expv) $display("FAIL rstmid got=%b want=%b", obs, expv); else n_pass++;
        n_chk++;
        if (clk_o !== 1'b0 || state_o !== IDLE) $display("FAIL rstmid_idle got=%b/%0d want=0/%0d", clk_o, state_o, IDLE); else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
            if (obs !== expv) $display("FAIL rstmid_run got=%b want=%b", obs, expv); else n_pass++;
            n_chk++;
            if (clk_o !== pat_n4[i]) $display("FAIL rstmid_pat i=%0d got=%b want=%b", i, clk_o, pat_n4[i]); else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) en_i = ~en_i;
            div_vld_i = ($urandom_range(0, 3) == 0);
            div_i     = DIV_W'($urandom_range(0, 9));
`ifdef CLK_DIV_PROG_DUTY_EN
            high_i    = DIV_W'($urandom_range(0, 10));
`endif
            cycle();
            n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
            if (obs !== expv) $display("FAIL random t=%0t got=%b want=%b", $time, obs, expv); else n_pass++;
        end
        div_vld_i = 1'b0;
        en_i = 1'b0;
        for (int i = 0; i < 40 && (running_o || !div_rdy_o); i++) begin
            cycle();
            n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
            if (obs !== expv) $display("FAIL random_drain got=%b want=%b", obs, expv); else n_pass++;
        end
        n_chk++;
        if (running_o !== 1'b0 || div_rdy_o !== 1'b1) $display("FAIL random_drain_timeout got=%b/%b want=0/1", running_o, div_rdy_o); else n_pass++;
    endtask

`ifdef CLK_DIV_PROG_DUTY_EN
    task automatic test_duty();
        int highs = 0;
        div_i = 8'd8; high_i = 8'd2; div_vld_i = 1'b1;
        cycle();
        n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
        if (obs !== expv) $display("FAIL duty_load got=%b want=%b", obs, expv); else n_pass++;
        div_vld_i = 1'b0;
        cycle();
        n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
        if (obs !== expv) $display("FAIL duty_apply got=%b want=%b", obs, expv); else n_pass++;
        en_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
            if (obs !== expv) $display("FAIL duty t=%0t got=%b want=%b", $time, obs, expv); else n_pass++;
            highs += int'(clk_o);
        end
        n_chk++;
        if (highs != 2) $display("FAIL duty_high2 got=%0d want=2", highs); else n_pass++;
        high_i = 8'd0; div_vld_i = 1'b1;
        cycle();
        n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
        if (obs !== expv) $display("FAIL duty_load0 got=%b want=%b", obs, expv); else n_pass++;
        div_vld_i = 1'b0;
        for (int i = 0; i < 24; i++) begin
            cycle();
            n_chk++; obs = {clk_o, rise_o, fall_o, div_rdy_o, running_o}; expv = exp_q.pop_front();
            if (obs !== expv) $display("FAIL duty0 t=%0t got=%b want=%b", $time, obs, expv); else n_pass++;
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_default_ratio();
        test_odd_ratio();
        test_rate_change();
        test_stop_clamp();
        test_reset_mid();
        test_random();
`ifdef CLK_DIV_PROG_DUTY_EN
        test_duty();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Programmable integer clock divider producing a registered divided clock `clk_o` plus single-cycle edge strobes (`rise_o`, `fall_o`) for use as clock enables.
- Generalised successor to the fixed power-of-two divider chains: any ratio 2..2^DIV_W-1 at runtime.
- Rate changes are glitch-free, applied only at period boundaries.
- Start/stop is clean: no runt pulses on `clk_o`.

Parameters:
- DIV_W, 16, width of the ratio bus and internal period counter.
- DIV_RST, 2, ratio active after reset; must be >= 2 and < 2^DIV_W.

Ports:
- clk_i  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- en_i  in  1  run request; 1 = generate `clk_o`, 0 = stop at end of current period.
- div_i  in  DIV_W  requested ratio N; output period is N `clk_i` cycles.
- div_vld_i  in  1  request to load `div_i`.
- div_rdy_o  out  1  1 = no ratio pending; a load is accepted when div_vld_i && div_rdy_o.
- clk_o  out  1  divided clock, registered.
- rise_o  out  1  high for exactly the first cycle of each `clk_o` high phase.
- fall_o  out  1  high for exactly the first cycle of each `clk_o` low phase that follows a high phase.
- running_o  out  1  state != IDLE.

Behaviour:
- **Reset (rst=1 at a clock edge):**
  - State IDLE, cnt=0, active ratio N=DIV_RST, no pending ratio.
  - clk_o=0, rise_o=0, fall_o=0, div_rdy_o=1, running_o=0.
  - Reset mid-period truncates immediately; the next period starts fresh.
- **Ratio clamp:**
  - Any accepted div_i < 2 is stored as 2.
  - No error flag.
- **Phase split:**
  - L = floor(N/2) low cycles, then H = N-L high cycles (odd N gets the extra cycle high).
  - Invariant: clk_o == (cnt >= L), with clk_o registered from the next-state cnt.
- **Counter:**
  - Counts 0..N-1 while state != IDLE.
  - Wraps N-1 -> 0; the wrap is the period boundary.
- **State machine:**
  - IDLE: cnt held 0, clk_o=0. en_i=1 -> RUN; cnt starts counting the next cycle, so the first period is complete (L low, H high).
  - RUN: en_i=0 -> STOPPING.
  - STOPPING: counting continues. en_i=1 -> RUN with no disturbance. At the wrap (cnt N-1 -> 0) -> IDLE.
  - Net effect of a stop: the final high phase is always full length.
- **Ratio handshake:**
  - div_vld_i && div_rdy_o latches the clamped div_i into the pending register; div_rdy_o drops next cycle.
  - div_vld_i while div_rdy_o=0 is ignored; the requester must hold it.
  - Pending value becomes active N:
    - at the next wrap in RUN/STOPPING;
    - the cycle after acceptance in IDLE.
  - div_rdy_o returns to 1 in the cycle N updates.
  - If a wrap and an acceptance fall in the same cycle, the newly accepted value waits for the following wrap.
- **Edge strobes:**
  - rise_o=1 in the first cycle clk_o=1 of a period.
  - fall_o=1 in the first cycle clk_o=0 after a high phase, including the final fall entering IDLE.
  - Both registered; never high simultaneously.
- **Latency:** div_i changes never alter the current period.

Optional Feature:
- Macro: CLK_DIV_PROG_DUTY_EN.
- Defined:
  - Adds input `high_i` [DIV_W-1:0], latched alongside div_i on the same handshake.
  - H = high_i clamped to 1..N-1; L = N-H.
- Undefined:
  - No `high_i` port.
  - H = ceil(N/2) as above.

Decomposition:
- Package `clk_div_prog_pkg`:
  - state enum {IDLE, RUN, STOPPING};
  - constant DIV_MIN=2;
  - clamp function for ratio (and high count when the duty feature is enabled).
- Sub-module `clk_div_ratio_hold`:
  - pending register, valid/ready handshake, clamping, apply-on-boundary update of the active ratio/high values.
- Top holds the FSM, counter and outputs.

Test Plan:
- **Reset and idle:** release rst, en_i=0 for 20 cycles -> clk_o=0, strobes 0, div_rdy_o=1, running_o=0 throughout.
- **Default ratio:** DIV_RST=4, en_i=1 -> clk_o pattern 0,0,1,1 repeating; rise_o once and fall_o once per 4 cycles.
- **Odd ratio:** load N=5 in IDLE, then en_i=1 -> 2 low, 3 high repeating.
- **Rate change:** load N=6 while running N=4 mid-period -> current 4-cycle period completes; next period 3 low/3 high; div_rdy_o low from acceptance until the boundary; a second div_vld_i while not ready is ignored.
- **Clean stop and clamp:** drop en_i during a high phase -> high phase finishes, fall_o pulses, running_o=0 after the wrap. Loading div_i=0 or 1 -> runs as N=2.
- **Reset mid-operation:** assert rst while clk_o=1 -> next cycle clk_o=0, IDLE, N=DIV_RST.
- **Duty feature (CLK_DIV_PROG_DUTY_EN):** N=8, high_i=2 -> 6 low/2 high; high_i=0 -> 1 high.
